// File: rtl/cia_e_clock_sequencer_pkg.sv
// Shared definitions for the CIA E-clock / VPA-VMA peripheral access sequencer.
package amigo_pkg;

  localparam int E_PERIOD_DEF = 10;
  localparam int E_HIGH_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_VMA    = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } cia_seq_state_t;

  // Number of CLKs per E period during which E is low.
  function automatic int low_len(input int e_period, input int e_high);
    return e_period - e_high;
  endfunction

endpackage

// File: rtl/cia_e_clock_sequencer_if.sv
// CPU-side strobes in, E clock / VMA / 74F139 decoder controls out.
interface cia_e_clock_sequencer_if #(
  parameter int SEL_W = 2
);
  logic             _AS;
  logic             _VPA_REQ;
  logic [SEL_W-1:0] A_IN;
  logic             E;
  logic             _VMA;
  logic             _DEC_EN;
  logic [SEL_W-1:0] DEC_A;
  logic             _CYCLE_END;

  modport master (
    output _AS, _VPA_REQ, A_IN,
    input  E, _VMA, _DEC_EN, DEC_A, _CYCLE_END
  );

  modport slave (
    input  _AS, _VPA_REQ, A_IN,
    output E, _VMA, _DEC_EN, DEC_A, _CYCLE_END
  );
endinterface

// File: rtl/cia_e_clock_sequencer_e_clock_gen.sv
// Free-running E-period counter with registered E and phase-point strobes
// decoded from the current count.
module e_clock_gen
  import amigo_pkg::*;
#(
  parameter int E_PERIOD = E_PERIOD_DEF,
  parameter int E_HIGH   = E_HIGH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(E_PERIOD)-1:0] ecnt,
  output logic                        e,
  output logic                        vma_pt,
  output logic                        rise_pt,
  output logic                        wrap_pt
);

  localparam int CNT_W   = $clog2(E_PERIOD);
  localparam int LOW_LEN = low_len(E_PERIOD, E_HIGH);

  logic [CNT_W-1:0] ecnt_next;

  always_comb begin
    ecnt_next = '0;
    if (ecnt != CNT_W'(E_PERIOD - 1))
      ecnt_next = ecnt + CNT_W'(1);
  end

  // E is registered from the next count so it always agrees with ecnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt <= '0;
      e    <= 1'b0;
    end else begin
      ecnt <= ecnt_next;
      e    <= (ecnt_next >= CNT_W'(LOW_LEN));
    end
  end

  assign vma_pt  = (ecnt == CNT_W'(LOW_LEN - 4));
  assign rise_pt = (ecnt == CNT_W'(LOW_LEN - 1));
  assign wrap_pt = (ecnt == CNT_W'(E_PERIOD - 1));

endmodule

// File: rtl/cia_e_clock_sequencer.sv
// Sequences one synchronised 6800-style peripheral access per address strobe,
// gating the 74F139 decoder enable to the E-high window.
module cia_e_clock_sequencer
  import amigo_pkg::*;
#(
  parameter int E_PERIOD = E_PERIOD_DEF,
  parameter int E_HIGH   = E_HIGH_DEF,
  parameter int SEL_W    = 2
) (
  input logic                     CLK,
  input logic                     _RESET,
  cia_e_clock_sequencer_if.slave  bus
);

  localparam int CNT_W   = $clog2(E_PERIOD);
  localparam int LOW_LEN = low_len(E_PERIOD, E_HIGH);

  logic [CNT_W-1:0] ecnt;
  logic             e;
  logic             vma_pt;
  logic             rise_pt;
  logic             wrap_pt;

  cia_seq_state_t   state;
  logic             vma_n;
  logic             dec_en_n;
  logic             cycle_end_n;
  logic [SEL_W-1:0] dec_a;

  e_clock_gen #(
    .E_PERIOD (E_PERIOD),
    .E_HIGH   (E_HIGH)
  ) u_e_clock_gen (
    .clk     (CLK),
    .rst_n   (_RESET),
    .ecnt    (ecnt),
    .e       (e),
    .vma_pt  (vma_pt),
    .rise_pt (rise_pt),
    .wrap_pt (wrap_pt)
  );

  // Once past SYNC the cycle is committed and runs to the E falling edge.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state       <= ST_IDLE;
      vma_n       <= 1'b1;
      dec_en_n    <= 1'b1;
      cycle_end_n <= 1'b1;
      dec_a       <= '0;
    end else begin
      cycle_end_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!bus._AS && !bus._VPA_REQ) begin
            dec_a <= bus.A_IN;
            state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bus._AS) begin
            state <= ST_IDLE;
          end else if (vma_pt) begin
            vma_n <= 1'b0;
            state <= ST_VMA;
          end
        end
        ST_VMA: begin
          if (rise_pt) begin
            dec_en_n <= 1'b0;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (wrap_pt) begin
            dec_en_n    <= 1'b1;
            vma_n       <= 1'b1;
            cycle_end_n <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus._AS)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The decoder may only be enabled inside the E-high window with VMA asserted.
  assert property (@(posedge CLK) disable iff (!_RESET)
    !dec_en_n |-> (e && !vma_n && (ecnt >= CNT_W'(LOW_LEN))));

  assign bus.E          = e;
  assign bus._VMA       = vma_n;
  assign bus._DEC_EN    = dec_en_n;
  assign bus.DEC_A      = dec_a;
  assign bus._CYCLE_END = cycle_end_n;

endmodule

// File: tb/tb_cia_e_clock_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed access timing, a negedge
// monitor checks E phase, invariants and each access against the queue.
module tb_cia_e_clock_sequencer;

  localparam int LOW = 6;

  typedef struct {
    logic [1:0] sel;
    int         vma_cyc;
    int         dec_cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;
  int   cyc;
  int   ph;
  int   dec_start;
  logic prev_vma;
  logic prev_dec;
  logic prev_cend;
  exp_t exp_q[$];

  cia_e_clock_sequencer_if #(.SEL_W(2)) bus_if ();

  cia_e_clock_sequencer #(
    .E_PERIOD (10),
    .E_HIGH   (4),
    .SEL_W    (2)
  ) dut (
    .CLK    (clk),
    ._RESET (reset_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected ecnt, kept independently of the design.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ph <= 0;
    else          ph <= (ph == 9) ? 0 : ph + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_vma  = 1'b1;
      prev_dec  = 1'b1;
      prev_cend = 1'b1;
    end else begin
      checkOutput("e_phase", 32'(bus_if.E), 32'(ph >= LOW));
      if (!bus_if._DEC_EN) begin
        checkOutput("inv_vma_low", 32'(bus_if._VMA), 0);
        checkOutput("inv_e_high", 32'(bus_if.E), 1);
        if (exp_q.size() != 0)
          checkOutput("dec_a_stable", 32'(bus_if.DEC_A), 32'(exp_q[0].sel));
      end
      if (prev_vma && !bus_if._VMA) begin
        checkOutput("vma_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) checkOutput("vma_start", cyc, exp_q[0].vma_cyc);
      end
      if (!prev_vma && bus_if._VMA)
        checkOutput("vma_end_with_cycle_end", 32'(bus_if._CYCLE_END), 0);
      if (prev_dec && !bus_if._DEC_EN) begin
        dec_start = cyc;
        checkOutput("dec_en_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          checkOutput("dec_en_start", cyc, exp_q[0].dec_cyc);
          checkOutput("dec_a", 32'(bus_if.DEC_A), 32'(exp_q[0].sel));
        end
      end
      if (!prev_dec && bus_if._DEC_EN)
        checkOutput("dec_en_len", cyc - dec_start, 4);
      if (!prev_cend)
        checkOutput("cycle_end_width", 32'(bus_if._CYCLE_END), 1);
      if (prev_cend && !bus_if._CYCLE_END) begin
        checkOutput("cycle_end_expected", 32'(exp_q.size() != 0), 1);
        checkOutput("vma_high_at_end", 32'(bus_if._VMA), 1);
        if (exp_q.size() != 0) begin
          checkOutput("cycle_end_time", cyc, exp_q[0].dec_cyc + 4);
          void'(exp_q.pop_front());
        end
      end
      prev_vma  = bus_if._VMA;
      prev_dec  = bus_if._DEC_EN;
      prev_cend = bus_if._CYCLE_END;
    end
  end

  task automatic waitPhase(input int p);
    int budget;
    budget = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (ph != p && budget < 30);
    if (ph != p) checkOutput("phase_wait", ph, p);
  endtask

  // Request sampled at the edge ending ecnt==p; offsets are from that cycle.
  task automatic applyStimulus(input int p, input logic [1:0] sel, input bit expect_access,
                               input int vma_off, input int dec_off,
                               input int as_off_ph, input int hold);
    int budget;
    waitPhase(p);
    bus_if.A_IN     = sel;
    bus_if._AS      = 1'b0;
    bus_if._VPA_REQ = 1'b0;
    if (expect_access) exp_q.push_back('{sel, cyc + vma_off, cyc + dec_off});
    if (as_off_ph >= 0) begin
      waitPhase(as_off_ph);
      bus_if._AS = 1'b1;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 60) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) checkOutput("access_timeout", exp_q.size(), 0);
    repeat (hold) @(posedge clk);
    #1;
    bus_if._AS      = 1'b1;
    bus_if._VPA_REQ = 1'b1;
    bus_if.A_IN     = ~sel;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests           = 0;
    fails           = 0;
    cyc             = 0;
    dec_start       = 0;
    prev_vma        = 1'b1;
    prev_dec        = 1'b1;
    prev_cend       = 1'b1;
    reset_n         = 1'b1;
    bus_if._AS      = 1'b1;
    bus_if._VPA_REQ = 1'b1;
    bus_if.A_IN     = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_e", 32'(bus_if.E), 0);
    checkOutput("reset_vma", 32'(bus_if._VMA), 1);
    checkOutput("reset_dec_en", 32'(bus_if._DEC_EN), 1);
    checkOutput("reset_dec_a", 32'(bus_if.DEC_A), 0);
    checkOutput("reset_cycle_end", 32'(bus_if._CYCLE_END), 1);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    $display("[TB] reset released, idling 50 CLKs");
    repeat (50) @(posedge clk);

    applyStimulus(0, 2'b10, 1'b1, 3,  6,  -1, 1);
    applyStimulus(4, 2'b11, 1'b1, 9,  12, -1, 1);
    applyStimulus(9, 2'b01, 1'b1, 4,  7,  -1, 1);
    applyStimulus(1, 2'b00, 1'b1, 2,  5,  -1, 1);
    applyStimulus(2, 2'b10, 1'b1, 11, 14, -1, 1);
    applyStimulus(0, 2'b11, 1'b0, 0,  0,  1,  20);
    applyStimulus(0, 2'b01, 1'b1, 3,  6,  7,  1);
    applyStimulus(0, 2'b11, 1'b1, 3,  6,  -1, 30);
    applyStimulus(0, 2'b01, 1'b1, 3,  6,  -1, 1);

    $display("[TB] asynchronous reset during ACCESS");
    waitPhase(0);
    bus_if.A_IN     = 2'b11;
    bus_if._AS      = 1'b0;
    bus_if._VPA_REQ = 1'b0;
    exp_q.push_back('{2'b11, cyc + 3, cyc + 6});
    waitPhase(7);
    checkOutput("pre_reset_dec_en", 32'(bus_if._DEC_EN), 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_e", 32'(bus_if.E), 0);
    checkOutput("async_reset_vma", 32'(bus_if._VMA), 1);
    checkOutput("async_reset_dec_en", 32'(bus_if._DEC_EN), 1);
    checkOutput("async_reset_cycle_end", 32'(bus_if._CYCLE_END), 1);
    checkOutput("async_reset_dec_a", 32'(bus_if.DEC_A), 0);
    exp_q.delete();
    bus_if._AS      = 1'b1;
    bus_if._VPA_REQ = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clk);
    applyStimulus(0, 2'b10, 1'b1, 3, 6, -1, 1);

    repeat (5) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cia_e_clock_sequencer.md
Name: cia_e_clock_sequencer

Overview:
- Generates the 68000-style E clock and the 6800-peripheral (VPA/VMA) access sequence for the CIA address space.
- Sits directly upstream of the TTL 74F139 dual 2-to-4 decoder model.
- Drives that decoder's active-low enable and its A1/A0 select inputs, so the decoded chip selects assert only during the E-high window of a synchronised peripheral cycle.

Parameters:
- E_PERIOD, 10: CLK cycles per E period (range 6..16).
- E_HIGH, 4: CLK cycles E is high per period; the low phase is LOW_LEN = E_PERIOD - E_HIGH (minimum 4).
- SEL_W, 2: width of the latched select field driven to the decoder.

Ports:
- CLK  in  1  CPU clock (7M domain); all state changes on its rising edge.
- _RESET  in  1  asynchronous, active-low reset.
- _AS  in  1  CPU address strobe, active-low.
- _VPA_REQ  in  1  active-low; upstream address decode says the current address is in peripheral space.
- A_IN  in  SEL_W  address bits selecting the peripheral; sampled when the request is accepted.
- E  out  1  E clock.
- _VMA  out  1  valid memory address, active-low.
- _DEC_EN  out  1  active-low enable to the decoder's _E input.
- DEC_A  out  SEL_W  latched select to the decoder; bit 1 drives A1, bit 0 drives A0.
- _CYCLE_END  out  1  one-CLK active-low pulse marking the end of the peripheral cycle.

Behaviour:
- Reset (asynchronous, _RESET low): ecnt=0, E=0, _VMA=1, _DEC_EN=1, DEC_A=0, _CYCLE_END=1, state=IDLE. Takes effect immediately, even mid-cycle; no partial cycle completes afterwards.
- E counter:
  - ecnt is a free-running counter 0..E_PERIOD-1 that wraps to 0.
  - Registered E = 1 exactly while ecnt >= LOW_LEN. With defaults, E is low for ecnt 0..5 and high for 6..9.
  - E is independent of the FSM.
- FSM states: IDLE, SYNC, VMA, ACCESS, DONE.
- IDLE:
  - If _AS=0 and _VPA_REQ=0, latch A_IN into DEC_A and go to SYNC.
  - DEC_A holds its value until the next accepted request.
- SYNC:
  - If _AS=1, return to IDLE (abort; no _VMA, no decoder enable).
  - Else at the edge where current ecnt == LOW_LEN-4, go to VMA and drive _VMA=0. _VMA is therefore visible from ecnt = LOW_LEN-3 (3 with defaults).
  - A request arriving after that point waits a full E period.
- VMA: at the edge where ecnt advances LOW_LEN-1 -> LOW_LEN (the same edge E rises), drive _DEC_EN=0 and go to ACCESS.
- ACCESS:
  - _DEC_EN stays low for exactly E_HIGH CLKs.
  - At the wrap edge (ecnt E_PERIOD-1 -> 0, E falls): _DEC_EN=1, _VMA=1, _CYCLE_END=0 for one CLK, go to DONE.
- DONE: _CYCLE_END returns to 1 after one CLK; stay until _AS=1, then go to IDLE. This guarantees one access per strobe.
- Once in VMA or ACCESS, _AS negation is ignored and the cycle runs to the E falling edge.
- _VPA_REQ is sampled only in IDLE; changes during later states are ignored.
- Invariants:
  - _DEC_EN=0 implies _VMA=0 and E=1.
  - DEC_A is stable whenever _DEC_EN=0.
- Latency, default parameters:
  - Request accepted → _DEC_EN low: 4 to 13 CLKs, depending on E phase.
  - Total cycle (request → _CYCLE_END): E_PERIOD-aligned.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `amigo_pkg`:
  - FSM state enum (`cia_seq_state_t`).
  - Default constants `E_PERIOD_DEF` = 10 and `E_HIGH_DEF` = 4.
  - Derived `LOW_LEN` function.
- One natural sub-module: `e_clock_gen`, holding the counter and registered E, with outputs ecnt, E, and a one-hot strobe per phase point (vma_pt, rise_pt, wrap_pt).
- The FSM consumes the `e_clock_gen` strobes only.

Test Plan:
- Reset release with no request → E period 10 CLKs, low 6, high 4; _VMA, _DEC_EN and _CYCLE_END stay 1 for 50 CLKs.
- Request (_AS=0, _VPA_REQ=0, A_IN=2'b10) at ecnt=0 → _VMA low from ecnt=3; _DEC_EN low for ecnt 6..9 with DEC_A=2'b10; _CYCLE_END low at ecnt=0 of the next period; _VMA high at the same edge.
- Request at ecnt=4 (misses sync) → no _VMA this period; _VMA low at ecnt=3 of the next period; _DEC_EN low 12 CLKs after request.
- _AS negated in SYNC at ecnt=1 → return to IDLE; _VMA and _DEC_EN never assert. _AS negated during ACCESS → _DEC_EN still low for the full 4 CLKs.
- _AS held low after _CYCLE_END for 30 CLKs → no second cycle. _AS high then low again with A_IN=2'b01 → new cycle with DEC_A=2'b01.
- _RESET low at ecnt=7 during ACCESS → _DEC_EN, _VMA and _CYCLE_END go to 1 and E to 0 asynchronously, before the next CLK edge. After release, the counter restarts at 0.
